axis_lfsr_burst_ctrl: RTL and testbench

Burst scheduler for the 64-bit pseudo-random AXI4-Stream source. It owns an internal LFSR word generator and sequences it into a programmed number of fixed-length packets separated by idle gaps, with `tlast` framing. It sits between the configuration/status register bank and any stream sink used for link, DMA or DAC pattern testing.

---
 rtl/axis_lfsr_pkg.sv | 26 ++
 rtl/lfsr64_gen.sv | 31 +++
 rtl/axis_lfsr_burst_ctrl.sv | 175 +++++++++++++++++
 tb/tb_axis_lfsr_burst_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_lfsr_pkg.sv
// Shared types, constants and LFSR step function for the LFSR burst source.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, 64-bit reset seed, feedback tap indices and the
// single-step LFSR function used by lfsr64_gen.
package axis_lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [63:0] LFSR_SEED_DEFAULT = 64'h85fa_c8a1_658d_6f0d;

  localparam int LFSR_TAP_A = 62;
  localparam int LFSR_TAP_B = 61;

  // Shift left by one; the new LSB is the XNOR of the two taps. All-ones
  // is a fixed point of this map.
  function automatic logic [63:0] lfsr_step(input logic [63:0] cur);
    return {cur[62:0], ~(cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B])};
  endfunction

endpackage

// File: rtl/lfsr64_gen.sv
// 64-bit XNOR LFSR word register with synchronous load and advance.
// Latency: load/advance visible on word the cycle after the edge.
// Backpressure: none; the caller advances only on a stream handshake.
//
// Ports:
//   aclk, aresetn  clock, async active-low reset (word -> default seed)
//   load, seed     load seed (has priority over advance)
//   advance        step the LFSR by one position
//   word           current LFSR value
module lfsr64_gen
  import axis_lfsr_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        advance,
  output logic [63:0] word
);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      word <= LFSR_SEED_DEFAULT;
    end else if (load) begin
      word <= seed;
    end else if (advance) begin
      word <= lfsr_step(word);
    end
  end

endmodule

// File: rtl/axis_lfsr_burst_ctrl.sv
// Burst scheduler: emits cfg_bursts packets of cfg_len LFSR words, cfg_gap idle cycles apart.
// Latency: start sampled at edge N gives tvalid from cycle N+1; one word per cycle after that.
// Backpressure: AXIS tready stalls the word in place; LFSR steps only on tvalid & tready.
//
// Ports:
//   aclk, aresetn                     clock, async active-low reset
//   cfg_len, cfg_gap, cfg_bursts      run configuration, latched on accepted start
//   cfg_seed                          LFSR seed (only with AXIS_LFSR_BURST_SEED_EN)
//   start, abort                      level-sampled run control
//   m_axis_tdata/tvalid/tlast/tready  AXI4-Stream master
//   sts_busy, sts_done, sts_bursts    status: running, completion pulse, bursts done
//
// Build option: define AXIS_LFSR_BURST_SEED_EN to add cfg_seed and reload the
// LFSR on every accepted start; otherwise the LFSR free-runs across runs.
module axis_lfsr_burst_ctrl
  import axis_lfsr_pkg::*;
#(
  parameter int CNTR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_len,
  input  logic [CNTR_WIDTH-1:0] cfg_gap,
  input  logic [CNTR_WIDTH-1:0] cfg_bursts,
`ifdef AXIS_LFSR_BURST_SEED_EN
  input  logic [63:0]           cfg_seed,
`endif
  input  logic                  start,
  input  logic                  abort,
  input  logic                  m_axis_tready,
  output logic [63:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic [CNTR_WIDTH-1:0] sts_bursts
);

  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [CNTR_WIDTH-1:0] len_q, len_d;
  logic [CNTR_WIDTH-1:0] gap_q, gap_d;
  logic [CNTR_WIDTH-1:0] bursts_q, bursts_d;
  logic [CNTR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNTR_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNTR_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic                  done_q, done_d;

  logic                  start_acc;
  logic                  beat_vld;
  logic                  beat_last;
  logic                  beat_hs;
  logic                  lfsr_load;
  logic [63:0]           lfsr_seed;
  logic [63:0]           lfsr_dat;

  // abort beats a simultaneous start; zero length or burst count is a no-op.
  assign start_acc = (state_q == ST_IDLE) && start && !abort &&
                     (cfg_len != '0) && (cfg_bursts != '0);

  assign beat_vld  = (state_q == ST_BURST);
  // Counter never exceeds len-1, so len = all-ones needs no extra width.
  assign beat_last = beat_vld && (word_cnt_q == len_q - CNT_ONE);
  assign beat_hs   = beat_vld && m_axis_tready;

`ifdef AXIS_LFSR_BURST_SEED_EN
  assign lfsr_load = start_acc;
  assign lfsr_seed = cfg_seed;
`else
  assign lfsr_load = 1'b0;
  assign lfsr_seed = LFSR_SEED_DEFAULT;
`endif

  lfsr64_gen u_lfsr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (lfsr_load),
    .seed    (lfsr_seed),
    .advance (beat_hs),
    .word    (lfsr_dat)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      bursts_q    <= '0;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      burst_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      bursts_q    <= bursts_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    gap_d       = gap_q;
    bursts_d    = bursts_q;
    word_cnt_d  = word_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    burst_cnt_d = burst_cnt_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d     = ST_BURST;
          len_d       = cfg_len;
          gap_d       = cfg_gap;
          bursts_d    = cfg_bursts;
          word_cnt_d  = '0;
          burst_cnt_d = '0;
        end
      end

      ST_BURST: begin
        // abort only takes effect once the offered word has been accepted.
        if (beat_hs) begin
          word_cnt_d = word_cnt_q + CNT_ONE;
          if (beat_last) begin
            word_cnt_d  = '0;
            burst_cnt_d = burst_cnt_q + CNT_ONE;
            if (burst_cnt_d == bursts_q) begin
              // Final word wins over a coincident abort.
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (abort) begin
              state_d = ST_IDLE;
            end else if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
            end
          end else if (abort) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q == gap_q - CNT_ONE) begin
          state_d = ST_BURST;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // tdata is forced to zero outside BURST so every output reads 0 in reset.
  assign m_axis_tvalid = beat_vld;
  assign m_axis_tlast  = beat_last;
  assign m_axis_tdata  = beat_vld ? lfsr_dat : 64'd0;
  assign sts_busy      = (state_q != ST_IDLE);
  assign sts_done      = done_q;
  assign sts_bursts    = burst_cnt_q;

endmodule

// File: tb/tb_axis_lfsr_burst_ctrl.sv
// Scoreboard bench for axis_lfsr_burst_ctrl: the stimulus pushes expected beats, a monitor pops them.
// Latency: n/a (testbench).
// Backpressure: tready is driven constant or randomized per scenario.
module tb_axis_lfsr_burst_ctrl;

  localparam int          CW       = 32;
  localparam logic [63:0] SEED_RST = 64'h85fa_c8a1_658d_6f0d;

  typedef struct packed {
    logic [63:0] dat;
    logic        last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CW-1:0] cfg_len = '0;
  logic [CW-1:0] cfg_gap = '0;
  logic [CW-1:0] cfg_bursts = '0;
`ifdef AXIS_LFSR_BURST_SEED_EN
  logic [63:0]   cfg_seed = SEED_RST;
`endif
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic [63:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          sts_busy;
  logic          sts_done;
  logic [CW-1:0] sts_bursts;

  axis_lfsr_burst_ctrl #(.CNTR_WIDTH(CW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_len       (cfg_len),
    .cfg_gap       (cfg_gap),
    .cfg_bursts    (cfg_bursts),
`ifdef AXIS_LFSR_BURST_SEED_EN
    .cfg_seed      (cfg_seed),
`endif
    .start         (start),
    .abort         (abort),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .sts_busy      (sts_busy),
    .sts_done      (sts_done),
    .sts_bursts    (sts_bursts)
  );

  always #5 aclk = ~aclk;

  int          n_chk = 0;
  int          n_pass = 0;
  beat_t       exp_q[$];
  logic [63:0] mdl_lfsr = SEED_RST;
  int          exp_gap = 0;
  int          done_cnt = 0;
  int          rdy_mode = 0;   // 0: drive rdy_val, 1: random
  logic        rdy_val = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Sequence rule: shift left by one and append (bit62 XNOR bit61).
  function automatic logic [63:0] mdl_step(input logic [63:0] v);
    logic nb;
    nb = (v[62] == v[61]);
    return (v << 1) | {63'd0, nb};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_run(input int len, input int bursts);
    beat_t nb;
`ifdef AXIS_LFSR_BURST_SEED_EN
    mdl_lfsr = cfg_seed;
`endif
    for (int b = 0; b < bursts; b++) begin
      for (int w = 0; w < len; w++) begin
        nb.dat  = mdl_lfsr;
        nb.last = (w == len - 1);
        exp_q.push_back(nb);
        mdl_lfsr = mdl_step(mdl_lfsr);
      end
    end
  endtask

  // After an abort, the first unconsumed expected word is where the LFSR sits.
  task automatic resync();
    if (exp_q.size() != 0) mdl_lfsr = exp_q[0].dat;
    exp_q.delete();
  endtask

  always @(posedge aclk) begin
    #2;
    if (rdy_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
    else m_axis_tready = rdy_val;
  end

  // Monitor: beat scoreboard, stall stability, gap length, done timing.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_dat = '0;
  logic        prev_last = 1'b0;
  logic        prev_hs_last = 1'b0;
  logic        trk = 1'b0;
  int          idle_n = 0;
  beat_t       mb;
  logic        hs;

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall   = 1'b0;
      prev_hs_last = 1'b0;
      trk          = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_data", m_axis_tdata, prev_dat);
        chk("stall_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid) begin
        if (trk) begin
          chk("gap_len", 64'(idle_n), 64'(exp_gap));
          trk = 1'b0;
        end
      end else if (trk) begin
        if (!sts_busy) trk = 1'b0;
        else idle_n++;
      end else if (sts_busy) begin
        chk("no_bubble", 64'(m_axis_tvalid), 64'd1);
      end
      if (sts_done) begin
        done_cnt++;
        chk("done_after_final", 64'(prev_hs_last), 64'd1);
        chk("busy_at_done", 64'(sts_busy), 64'd0);
      end
      hs = m_axis_tvalid & m_axis_tready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL beat_unexpected: got data 0x%0h, expected no beat", m_axis_tdata);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_data", m_axis_tdata, mb.dat);
          chk("beat_last", 64'(m_axis_tlast), 64'(mb.last));
        end
        if (m_axis_tlast) begin
          trk    = 1'b1;
          idle_n = 0;
        end
      end
      prev_hs_last = hs & m_axis_tlast;
      prev_stall   = m_axis_tvalid & ~m_axis_tready;
      prev_dat     = m_axis_tdata;
      prev_last    = m_axis_tlast;
    end
  end

  task automatic run(input int len, input int gap, input int bursts, input int mode, input bit poke);
    int d0;
    bit ended;
    cfg_len    = CW'(len);
    cfg_gap    = CW'(gap);
    cfg_bursts = CW'(bursts);
    exp_gap    = gap;
    rdy_mode   = mode;
    rdy_val    = 1'b1;
    push_run(len, bursts);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge aclk);
    chk("start_latency", 64'(m_axis_tvalid), 64'd1);
    if (poke) begin
      tick();
      tick();
      start   = 1'b1;
      cfg_len = CW'(7);
      tick();
      tick();
      start   = 1'b0;
      cfg_len = CW'(len);
    end
    ended = 1'b0;
    for (int i = 0; i < 3000 && !ended; i++) begin
      @(negedge aclk);
      if (!sts_busy) ended = 1'b1;
    end
    if (!ended) begin
      n_chk++;
      $display("FAIL run_timeout: busy still 1 after 3000 cycles, required 0");
    end
    tick();
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("sts_bursts", 64'(sts_bursts), 64'(bursts));
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit found;
    logic [63:0] w0;

    // Reset state
    repeat (3) tick();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_busy", 64'(sts_busy), 64'd0);
    chk("rst_done", 64'(sts_done), 64'd0);
    chk("rst_bursts", 64'(sts_bursts), 64'd0);
    aresetn = 1'b1;
    tick();

    // Single burst, gap timing, back-to-back with random backpressure
    run(4, 0, 1, 0, 0);
    run(2, 3, 3, 0, 0);
    run(5, 0, 2, 1, 0);

    // Start while busy must not disturb the sequence
    run(3, 2, 2, 0, 1);

    // Randomized runs
    for (int r = 0; r < 5; r++) begin
      run(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
          int'($urandom_range(1, 3)), 1, 0);
    end

    // Ignored starts
    cfg_len = '0; cfg_bursts = CW'(3); start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    @(negedge aclk);
    chk("ign_len0_busy", 64'(sts_busy), 64'd0);
    cfg_len = CW'(3); cfg_bursts = '0; start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    @(negedge aclk);
    chk("ign_bursts0_busy", 64'(sts_busy), 64'd0);
    cfg_bursts = CW'(2); start = 1'b1; abort = 1'b1;
    repeat (2) tick();
    start = 1'b0; abort = 1'b0;
    @(negedge aclk);
    chk("start_abort_busy", 64'(sts_busy), 64'd0);

    // Abort while stalled mid-burst
    cfg_len = CW'(4); cfg_gap = '0; cfg_bursts = CW'(2);
    rdy_mode = 0; rdy_val = 1'b0;
    tick();
`ifdef AXIS_LFSR_BURST_SEED_EN
    w0 = cfg_seed;
`else
    w0 = mdl_lfsr;
`endif
    push_run(4, 2);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    @(negedge aclk);
    chk("abort_hold_valid", 64'(m_axis_tvalid), 64'd1);
    chk("abort_hold_data", m_axis_tdata, w0);
    tick();
    rdy_val = 1'b1;
    tick();
    @(negedge aclk);
    chk("abort_burst_idle", 64'(sts_busy), 64'd0);
    abort = 1'b0;
    chk("abort_burst_cnt", 64'(sts_bursts), 64'd0);
    tick();
    tick();
    chk("abort_burst_nodone", 64'(done_cnt - d0), 64'd0);
    chk("abort_burst_one_beat", 64'(exp_q.size()), 64'd7);
    resync();

    // Abort during GAP
    cfg_len = CW'(2); cfg_gap = CW'(5); cfg_bursts = CW'(2); exp_gap = 5;
    push_run(2, 2);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge aclk);
      if (sts_busy && !m_axis_tvalid) found = 1'b1;
    end
    chk("gap_reached", 64'(found), 64'd1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge aclk);
    chk("abort_gap_idle", 64'(sts_busy), 64'd0);
    chk("abort_gap_cnt", 64'(sts_bursts), 64'd1);
    chk("abort_gap_nodone", 64'(done_cnt - d0), 64'd0);
    resync();

    // Abort coincident with the final handshake completes normally
    cfg_len = CW'(2); cfg_gap = '0; cfg_bursts = CW'(1);
    push_run(2, 1);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge aclk);
      if (m_axis_tvalid && m_axis_tlast && m_axis_tready) found = 1'b1;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();
    chk("abort_final_done", 64'(done_cnt - d0), 64'd1);
    chk("abort_final_cnt", 64'(sts_bursts), 64'd1);
    chk("abort_final_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Maximum length: no tlast early, counter must not wrap to len-1
    cfg_len = '1; cfg_gap = '0; cfg_bursts = CW'(1);
    push_run(20, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("maxlen_no_tlast", 64'(m_axis_tlast), 64'd0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge aclk);
    chk("maxlen_abort_idle", 64'(sts_busy), 64'd0);
    resync();

    // LFSR continuity after aborts
    run(3, 1, 2, 1, 0);

`ifdef AXIS_LFSR_BURST_SEED_EN
    // Seed load, then a locked all-ones seed
    cfg_seed = 64'h1;
    run(3, 0, 1, 0, 0);
    cfg_seed = '1;
    run(3, 0, 1, 0, 0);
    cfg_seed = SEED_RST;
`endif

    // Reset mid-burst clears outputs without waiting for an edge
    cfg_len = CW'(10); cfg_gap = '0; cfg_bursts = CW'(1);
    push_run(10, 1);
    rdy_mode = 0; rdy_val = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    aresetn = 1'b0;
    #1;
    chk("rstmid_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rstmid_tdata", m_axis_tdata, 64'd0);
    chk("rstmid_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rstmid_busy", 64'(sts_busy), 64'd0);
    chk("rstmid_bursts", 64'(sts_bursts), 64'd0);
    tick();
    aresetn = 1'b1;
    exp_q.delete();
    mdl_lfsr = SEED_RST;
    tick();

    // LFSR restarts from the reset seed
    run(2, 0, 2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
